calc_operand_loader: RTL and testbench
======================================

// Module: calc_operand_loader
// PURPOSE
// - Upstream stage of the calculator datapath. Accepts a valid/ready stream of 64-bit operand words.
// - Writes each word into the SRAM pair through port 0 (write port) before the controller runs.
//   Bits [63:32] go to sram_A; bits [31:0] go to sram_B.
// - Fills addresses cfg_start_addr..cfg_end_addr (inclusive), then pulses done_o to hand off to the controller.
// PARAMETERS
// - ADDR_W         9   SRAM word address width (512 entries)
// - DATA_W         32  half-word width; one half per SRAM macro
// - MEM_WORD_SIZE  64  stream word width; must equal 2*DATA_W
// PORTS
// - clk_i           in   1              single clock; all state updates on rising edge
// - rst_i           in   1              reset, synchronous, active-low (0 = reset)
// - start_i         in   1              1-cycle pulse: latch cfg_*, begin load
// - cfg_start_addr  in   ADDR_W         first address written
// - cfg_end_addr    in   ADDR_W         last address written (inclusive)
// - s_valid_i       in   1              stream word valid
// - s_data_i        in   MEM_WORD_SIZE  stream word {A_half, B_half}
// - s_ready_o       out  1              loader accepts word this cycle
// - sram_csb0_o     out  1              port-0 chip select, active-low
// - sram_web0_o     out  1              port-0 write enable, active-low
// - sram_addr0_o    out  ADDR_W         port-0 address
// - sram_din_a_o    out  DATA_W         data to sram_A = s_data_i[63:32]
// - sram_din_b_o    out  DATA_W         data to sram_B = s_data_i[31:0]
// - busy_o          out  1              1 in any state other than IDLE/ERR
// - done_o          out  1              1-cycle pulse after final write
// - error_o         out  1              cfg_end_addr < cfg_start_addr; held until next start_i
// - words_o         out  ADDR_W+1       count of words written in the current/last load
// BEHAVIOUR
// - Reset: state=IDLE. s_ready_o=0, sram_csb0_o=1, sram_web0_o=1, addr/din=0, busy_o=0, done_o=0, error_o=0, words_o=0.
// - FSM states: IDLE, LOAD, DRAIN, DONE, ERR.
//   - IDLE: on start_i, check config.
//     - end<start -> ERR.
//     - Otherwise latch cfg_*, set ptr=cfg_start_addr, clear words_o, go to LOAD.
//   - LOAD: s_ready_o=1. On handshake (s_valid_i & s_ready_o) at cycle N, at the edge:
//     - register addr0=ptr and din_a/din_b from s_data_i;
//     - drive csb0=0 and web0=0 during cycle N+1;
//     - ptr++, words_o++.
//     - A handshake with ptr==end_addr -> DRAIN; s_ready_o drops in the next cycle.
//     - Throughput is 1 word/cycle; back-to-back handshakes give contiguous write strobes.
//   - DRAIN: the final write strobe is active; s_ready_o=0; go to DONE.
//   - DONE: done_o=1 for exactly this cycle, strobes inactive; go to IDLE.
//   - ERR: error_o=1, no writes, s_ready_o=0. start_i clears error_o and re-evaluates the config as in IDLE.
// - Write strobes: csb0/web0 are low only in the cycle after a handshake, and always low together.
//   No port-0 reads are ever issued.
// - start_i outside IDLE/ERR is ignored; latched config is unchanged.
// - Single-entry load (start==end): 1 handshake, 1 write, done_o 2 cycles after the handshake.
// - Full range 0..511 writes 512 words; ptr must not wrap past end_addr. words_o=512 needs ADDR_W+1 bits.
// - s_valid_i low in LOAD: no strobe, state holds indefinitely; s_data_i is ignored.
// - Reset mid-load: next edge returns all outputs to reset values and any pending write strobe is dropped.
//   SRAM contents already written are not cleared.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: adds output checksum_o [MEM_WORD_SIZE-1:0].
//   - Cleared on accepted start_i; XOR-accumulates every accepted s_data_i.
//   - Stable from done_o until the next start_i; reset value 0.
// - LOADER_CHECKSUM_EN undefined: no checksum_o port and no accumulator logic; all other behaviour is identical.
// TESTING
// - start=0x000,end=0x003; 4 words streamed back-to-back
//   -> strobes on 4 consecutive cycles, addr 0..3, din_a/din_b = upper/lower halves;
//   -> done_o pulses 2 cycles after the 4th handshake; words_o=4.
// - Same config, s_valid_i toggled 1,0,1,0...
//   -> strobes only in the cycle after each handshake; addresses stay contiguous; done_o after the 4th word.
// - start=0x010,end=0x00F -> error_o=1, no strobes, s_ready_o=0; then start=0x010,end=0x010 -> error_o clears, 1 write, done_o.
// - rst_i=0 after 2 of 5 words -> next cycle: csb0=web0=1, s_ready_o=0, busy_o=0, words_o=0; no further strobes.
// - start=0x000,end=0x1FF; 512 words -> last write at addr 0x1FF, words_o=512, no wrap write to 0x000.
// - LOADER_CHECKSUM_EN: words 0x1, 0x2, 0x4 -> checksum_o=0x7 at done_o; start_i mid-load is ignored.

Source files
------------

// File: rtl/calc_operand_loader.sv
// Streams 64-bit operand words into the sram_A/sram_B pair via write port 0.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of the accepted words.
module calc_operand_loader #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        cfg_start_addr,
    input  logic [ADDR_W-1:0]        cfg_end_addr,
    input  logic                     s_valid_i,
    input  logic [MEM_WORD_SIZE-1:0] s_data_i,
    output logic                     s_ready_o,
    output logic                     sram_csb0_o,
    output logic                     sram_web0_o,
    output logic [ADDR_W-1:0]        sram_addr0_o,
    output logic [DATA_W-1:0]        sram_din_a_o,
    output logic [DATA_W-1:0]        sram_din_b_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [ADDR_W:0]          words_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [MEM_WORD_SIZE-1:0] checksum_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   end_q;
    logic [ADDR_W:0]     words_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_a_q;
    logic [DATA_W-1:0]   din_b_q;

    logic start_ok;
    logic cfg_bad;
    logic hs;
    logic last;

    assign start_ok = start_i && (state_q == IDLE || state_q == ERR);
    assign cfg_bad  = cfg_end_addr < cfg_start_addr;
    assign hs       = s_valid_i && s_ready_o;
    assign last     = hs && (ptr_q == end_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ERR: begin
                if (start_i) state_d = cfg_bad ? ERR : LOAD;
            end
            LOAD:    if (last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            words_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_a_q <= '0;
            din_b_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= hs;
            if (start_ok && !cfg_bad) begin
                ptr_q   <= cfg_start_addr;
                end_q   <= cfg_end_addr;
                words_q <= '0;
            end
            if (hs) begin
                addr_q  <= ptr_q;
                din_a_q <= s_data_i[2*DATA_W-1:DATA_W];
                din_b_q <= s_data_i[DATA_W-1:0];
                words_q <= words_q + 1'b1;
                // hold ptr on the final word so a full 0..511 load never wraps
                if (!last) ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    assign s_ready_o    = (state_q == LOAD);
    assign sram_csb0_o  = ~wr_q;
    assign sram_web0_o  = ~wr_q;
    assign sram_addr0_o = addr_q;
    assign sram_din_a_o = din_a_q;
    assign sram_din_b_o = din_b_q;
    assign busy_o       = (state_q != IDLE) && (state_q != ERR);
    assign done_o       = (state_q == DONE);
    assign error_o      = (state_q == ERR);
    assign words_o      = words_q;

`ifdef LOADER_CHECKSUM_EN
    logic [MEM_WORD_SIZE-1:0] cks_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cks_q <= '0;
        end else if (start_ok) begin
            cks_q <= '0;
        end else if (hs) begin
            cks_q <= cks_q ^ s_data_i;
        end
    end

    assign checksum_o = cks_q;
`endif

endmodule

// File: tb/tb_calc_operand_loader.sv
// Scoreboard bench for calc_operand_loader: expected writes are queued at
// each handshake and a negedge monitor checks every port-0 write strobe.
module tb_calc_operand_loader;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] cfg_s;
    logic [AW-1:0] cfg_e;
    logic          s_valid;
    logic [MW-1:0] s_data;
    logic          s_ready;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din_a;
    logic [DW-1:0] din_b;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words;
`ifdef LOADER_CHECKSUM_EN
    logic [MW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    calc_operand_loader dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .start_i        (start),
        .cfg_start_addr (cfg_s),
        .cfg_end_addr   (cfg_e),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_ready_o      (s_ready),
        .sram_csb0_o    (csb0),
        .sram_web0_o    (web0),
        .sram_addr0_o   (addr0),
        .sram_din_a_o   (din_a),
        .sram_din_b_o   (din_b),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .words_o        (words)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_o     (checksum)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (csb0 !== 1'b1 || web0 !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h csb0 %0b web0 %0b",
                         addr0, csb0, web0);
            end else begin
                e = exp_q.pop_front();
                check("wr_csb0", csb0, 0);
                check("wr_web0", web0, 0);
                check("wr_addr", addr0, e.addr);
                check("wr_din_a", din_a, e.data[63:32]);
                check("wr_din_b", din_b, e.data[31:0]);
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
        @(posedge clk);
        #1;
        cfg_s = s;
        cfg_e = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [MW-1:0] d, input logic [AW-1:0] a);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: addr %0h got no ready", a);
        end else begin
            exp_q.push_back('{addr: a, data: d});
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // called right after the last handshake edge
    task automatic check_done(input logic [AW:0] w);
        @(negedge clk);
        check("done_early", done, 0);
        check("ready_drain", s_ready, 0);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("words", words, w);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        cfg_s   = '0;
        cfg_e   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_csb0", csb0, 1);
        check("rst_web0", web0, 1);
        check("rst_addr", addr0, 0);
        check("rst_din_a", din_a, 0);
        check("rst_din_b", din_b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // back-to-back 4-word load
        do_start(9'h000, 9'h003);
        check("busy_load", busy, 1);
        send(64'hA000_0000_B000_0000, 9'h000);
        send(64'hA111_1111_B111_1111, 9'h001);
        send(64'hA222_2222_B222_2222, 9'h002);
        send(64'hA333_3333_B333_3333, 9'h003);
        check_done(10'd4);

        // gapped stream with an ignored start mid-load
        do_start(9'h000, 9'h003);
        send(64'h0102_0304_0506_0708, 9'h000);
        idle_cycle();
        send(64'h1112_1314_1516_1718, 9'h001);
        do_start(9'h100, 9'h100);
        send(64'h2122_2324_2526_2728, 9'h002);
        idle_cycle();
        send(64'h3132_3334_3536_3738, 9'h003);
        check_done(10'd4);

        // bad config then recovery with a single-entry load
        do_start(9'h010, 9'h00F);
        @(negedge clk);
        check("err_set", error, 1);
        check("err_ready", s_ready, 0);
        check("err_busy", busy, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("err_hold", error, 1);
            check("err_no_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        do_start(9'h010, 9'h010);
        check("err_clear", error, 0);
        send(64'hCAFE_F00D_1234_5678, 9'h010);
        check_done(10'd1);

        // reset after 2 of 5 words
        do_start(9'h000, 9'h004);
        send(64'h5555_0000_6666_0000, 9'h000);
        send(64'h5555_0001_6666_0001, 9'h001);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h7777_0002_8888_0002;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_csb0", csb0, 1);
        check("mid_rst_web0", web0, 1);
        check("mid_rst_ready", s_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_words", words, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;

        // full range 0..511
        do_start(9'h000, 9'h1FF);
        for (int i = 0; i < 512; i++) begin
            send({32'(i) ^ 32'h5A5A_0000, ~32'(i)}, 9'(i));
        end
        check_done(10'd512);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 64'h1;
        repeat (3) begin
            @(negedge clk);
            check("full_no_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        do_start(9'h020, 9'h022);
        send(64'h1, 9'h020);
        do_start(9'h040, 9'h041);
        send(64'h2, 9'h021);
        send(64'h4, 9'h022);
        @(negedge clk);
        @(negedge clk);
        check("cks_done", done, 1);
        check("checksum", checksum, 64'h7);
        @(negedge clk);
        check("cks_hold", checksum, 64'h7);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
